// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-slot alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_e;

    localparam logic [5:0] MAX_HOUR = 6'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
    } slot_time_t;

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Slot write bus: one-clk wr_en pulse loads wr_hour:wr_min into slot wr_sel.
interface multi_alarm_ctrl_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [5:0]       wr_hour;
    logic [5:0]       wr_min;

    modport master (output wr_en, wr_sel, wr_hour, wr_min);
    modport slave  (input  wr_en, wr_sel, wr_hour, wr_min);
endinterface

// File: rtl/time_add_min.sv
// Wrapped hour:min + N_MIN minutes (minutes carry into hours, hours wrap at 24).
// Only present when ALARM_SNOOZE_EN is defined; nothing else needs it.
`ifdef ALARM_SNOOZE_EN
module time_add_min
    import alarm_pkg::*;
#(
    parameter int N_MIN = 9
) (
    input  slot_time_t t_in,
    output slot_time_t t_out
);
    logic [6:0] min_sum;
    logic       carry;
    logic [5:0] hour_inc;

    assign min_sum   = {1'b0, t_in.min} + 7'(N_MIN);
    assign carry     = min_sum > {1'b0, MAX_MIN};
    assign t_out.min = carry ? 6'(min_sum - 7'd60) : min_sum[5:0];
    assign hour_inc  = t_in.hour + {5'd0, carry};
    assign t_out.hour = (hour_inc > MAX_HOUR) ? 6'd0 : hour_inc;
endmodule
`endif

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm clock controller: slot registers, match detect, ring/snooze FSM.
// Macro ALARM_SNOOZE_EN builds the SNOOZE state and snooze target registers.
//
// state  | meaning
// IDLE   | waiting for an armed slot to match the current time
// RING   | alarm sounding; timeout counter runs on tick_1hz
// SNOOZE | silenced until the snooze target time, then rings again
module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 9,
    parameter int RING_TIMEOUT_S = 60,
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_1hz,
    input  logic [5:0]            hour_in,
    input  logic [5:0]            min_in,
    input  logic [5:0]            sec_in,
    multi_alarm_ctrl_if.slave     wr,
    input  logic [NUM_ALARMS-1:0] en_mask,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  ringing,
    output logic [SEL_W-1:0]      ring_id,
    output logic                  snoozing,
    output logic                  alarm_on
);
    localparam logic [7:0] CNT_LAST = 8'(RING_TIMEOUT_S - 1);

    alarm_state_e    state_q, state_d;
    logic [SEL_W-1:0] ring_id_q, ring_id_d;
    logic [7:0]      cnt_q, cnt_d;
    slot_time_t      slot_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match;
    logic [SEL_W-1:0] match_idx;
    logic            wr_ok;
    logic            stop_ring;

    assign wr_ok = wr.wr_en && (wr.wr_hour <= MAX_HOUR) && (wr.wr_min <= MAX_MIN)
                   && (int'(wr.wr_sel) < NUM_ALARMS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_ALARMS; k++) slot_q[k] <= '0;
        end else if (wr_ok) begin
            slot_q[wr.wr_sel] <= {wr.wr_hour, wr.wr_min};
        end
    end

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_ALARMS; k++)
            match[k] = en_mask[k] && tick_1hz && (sec_in == 6'd0)
                       && (hour_in == slot_q[k].hour) && (min_in == slot_q[k].min);
    end

    // Scan downward so the lowest matching slot wins.
    always_comb begin
        match_idx = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--)
            if (match[k]) match_idx = SEL_W'(k);
    end

    assign stop_ring = dismiss || !en_mask[ring_id_q];

`ifdef ALARM_SNOOZE_EN
    slot_time_t tgt_q, tgt_sum;
    logic       load_tgt;
    logic       tgt_hit;

    time_add_min #(.N_MIN(SNOOZE_MIN)) u_time_add_min (
        .t_in  ({hour_in, min_in}),
        .t_out (tgt_sum)
    );

    assign tgt_hit = tick_1hz && (sec_in == 6'd0)
                     && (hour_in == tgt_q.hour) && (min_in == tgt_q.min);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        tgt_q <= '0;
        else if (load_tgt) tgt_q <= tgt_sum;
    end
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ring_id_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ring_id_q <= ring_id_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ring_id_d = ring_id_q;
        cnt_d     = cnt_q;
`ifdef ALARM_SNOOZE_EN
        load_tgt  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|match) begin
                    state_d   = RING;
                    ring_id_d = match_idx;
                    cnt_d     = '0;
                end
            end
            RING: begin
                // Dismiss outranks snooze when both arrive together.
                if (stop_ring || (tick_1hz && cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    state_d  = SNOOZE;
                    load_tgt = 1'b1;
                end
`endif
                else if (tick_1hz) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (stop_ring) begin
                    state_d = IDLE;
                end else if (tgt_hit) begin
                    state_d = RING;
                    cnt_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign ringing  = (state_q == RING);
    assign snoozing = (state_q == SNOOZE);
    assign ring_id  = ring_id_q;
    assign alarm_on = |en_mask;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl; snooze scenarios follow ALARM_SNOOZE_EN.
module tb_multi_alarm_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [5:0] hour_in = '0, min_in = '0, sec_in = '0;
    logic [3:0] en_mask = '0;
    logic       snooze = 1'b0, dismiss = 1'b0;
    logic       ringing, snoozing, alarm_on;
    logic [1:0] ring_id;
    int         errors = 0;
    int         checks = 0;

    multi_alarm_ctrl_if #(.NUM_ALARMS(4)) wr_bus ();

    multi_alarm_ctrl #(.NUM_ALARMS(4), .SNOOZE_MIN(9), .RING_TIMEOUT_S(60)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .hour_in  (hour_in),
        .min_in   (min_in),
        .sec_in   (sec_in),
        .wr       (wr_bus.slave),
        .en_mask  (en_mask),
        .snooze   (snooze),
        .dismiss  (dismiss),
        .ringing  (ringing),
        .ring_id  (ring_id),
        .snoozing (snoozing),
        .alarm_on (alarm_on)
    );

    always #5 clk = ~clk;

    task automatic write_slot(input logic [1:0] sel, input logic [5:0] h, input logic [5:0] m);
        @(negedge clk);
        wr_bus.wr_en = 1'b1; wr_bus.wr_sel = sel; wr_bus.wr_hour = h; wr_bus.wr_min = m;
        @(negedge clk);
        wr_bus.wr_en = 1'b0;
    endtask

    task automatic pulse_tick(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        hour_in = h; min_in = m; sec_in = s; tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_ctl(input logic snz, input logic dis);
        @(negedge clk);
        snooze = snz; dismiss = dis;
        @(negedge clk);
        snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        en_mask = 4'b0101;
        #1;
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL reset_ringing: got %0b want 0", ringing); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %0b want 0", snoozing); end
        checks++; if (ring_id !== 2'd0) begin errors++; $display("FAIL reset_ring_id: got %0d want 0", ring_id); end
        checks++; if (alarm_on !== 1'b1) begin errors++; $display("FAIL reset_alarm_on: got %0b want 1", alarm_on); end
        en_mask = 4'b0000;
        #1;
        checks++; if (alarm_on !== 1'b0) begin errors++; $display("FAIL alarm_on_clear: got %0b want 0", alarm_on); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_ring();
        en_mask = 4'b0010;
        write_slot(2'd1, 6'd7, 6'd30);
        pulse_tick(6'd7, 6'd30, 6'd1);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL sec_nonzero_no_ring: got %0b want 0", ringing); end
        @(negedge clk);
        hour_in = 6'd7; min_in = 6'd30; sec_in = 6'd0; tick_1hz = 1'b1;
        #1;
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL ring_before_edge: got %0b want 0", ringing); end
        @(negedge clk);
        tick_1hz = 1'b0;
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL single_ringing: got %0b want 1", ringing); end
        checks++; if (ring_id !== 2'd1) begin errors++; $display("FAIL single_ring_id: got %0d want 1", ring_id); end
        pulse_ctl(1'b0, 1'b1);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL dismiss_ringing: got %0b want 0", ringing); end
    endtask

    task automatic test_bad_write();
        write_slot(2'd1, 6'd24, 6'd10);
        write_slot(2'd1, 6'd8, 6'd60);
        pulse_tick(6'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b1 || ring_id !== 2'd1) begin errors++; $display("FAIL bad_write_ignored: ringing=%0b id=%0d want 1/1", ringing, ring_id); end
        pulse_ctl(1'b0, 1'b1);
    endtask

    task automatic test_priority();
        en_mask = 4'b0101;
        write_slot(2'd0, 6'd6, 6'd0);
        write_slot(2'd2, 6'd6, 6'd0);
        write_slot(2'd2, 6'd6, 6'd0);
        pulse_tick(6'd6, 6'd0, 6'd0);
        checks++; if (ringing !== 1'b1 || ring_id !== 2'd0) begin errors++; $display("FAIL priority_lowest: ringing=%0b id=%0d want 1/0", ringing, ring_id); end
        write_slot(2'd2, 6'd6, 6'd1);
        pulse_tick(6'd6, 6'd1, 6'd0);
        checks++; if (ring_id !== 2'd0) begin errors++; $display("FAIL no_queue_id: got %0d want 0", ring_id); end
        pulse_ctl(1'b0, 1'b1);
        pulse_tick(6'd6, 6'd1, 6'd1);
        repeat (3) @(negedge clk);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL slot2_no_later_ring: got %0b want 0", ringing); end
    endtask

    task automatic test_en_clear();
        en_mask = 4'b0001;
        pulse_tick(6'd6, 6'd0, 6'd0);
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL en_clear_start: got %0b want 1", ringing); end
        en_mask = 4'b0100;
        @(negedge clk); @(negedge clk);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL en_clear_stop: got %0b want 0", ringing); end
    endtask

    task automatic test_timeout();
        en_mask = 4'b0001;
        pulse_tick(6'd6, 6'd0, 6'd0);
        write_slot(2'd0, 6'd9, 6'd0);
        for (int i = 0; i < 59; i++) pulse_tick(6'd12, 6'd34, 6'd56);
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL timeout_59: got %0b want 1", ringing); end
        pulse_tick(6'd12, 6'd34, 6'd56);
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL timeout_60: ringing=%0b snoozing=%0b want 0/0", ringing, snoozing); end
    endtask

    task automatic test_snooze();
        en_mask = 4'b1000;
        write_slot(2'd3, 6'd23, 6'd55);
        pulse_tick(6'd23, 6'd55, 6'd0);
        checks++; if (ringing !== 1'b1 || ring_id !== 2'd3) begin errors++; $display("FAIL snooze_ring: ringing=%0b id=%0d want 1/3", ringing, ring_id); end
        pulse_ctl(1'b1, 1'b0);
`ifdef ALARM_SNOOZE_EN
        checks++; if (snoozing !== 1'b1 || ringing !== 1'b0) begin errors++; $display("FAIL snooze_enter: snoozing=%0b ringing=%0b want 1/0", snoozing, ringing); end
        write_slot(2'd3, 6'd10, 6'd0);
        pulse_tick(6'd0, 6'd3, 6'd0);
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze_early: got %0b want 1", snoozing); end
        pulse_tick(6'd0, 6'd4, 6'd0);
        checks++; if (ringing !== 1'b1 || ring_id !== 2'd3 || snoozing !== 1'b0) begin errors++; $display("FAIL snooze_rering: ringing=%0b id=%0d snoozing=%0b want 1/3/0", ringing, ring_id, snoozing); end
        pulse_ctl(1'b0, 1'b1);
`else
        checks++; if (snoozing !== 1'b0 || ringing !== 1'b1) begin errors++; $display("FAIL snooze_ignored: snoozing=%0b ringing=%0b want 0/1", snoozing, ringing); end
        pulse_ctl(1'b0, 1'b1);
`endif
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL snooze_dismiss: ringing=%0b snoozing=%0b want 0/0", ringing, snoozing); end
    endtask

    task automatic test_snooze_and_dismiss();
        en_mask = 4'b0100;
        write_slot(2'd2, 6'd5, 6'd10);
        pulse_tick(6'd5, 6'd10, 6'd0);
        pulse_ctl(1'b1, 1'b1);
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL both_dismiss_wins: ringing=%0b snoozing=%0b want 0/0", ringing, snoozing); end
        pulse_ctl(1'b1, 1'b0);
        pulse_tick(6'd5, 6'd19, 6'd0);
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin errors++; $display("FAIL no_ring_after_both: ringing=%0b snoozing=%0b want 0/0", ringing, snoozing); end
    endtask

    task automatic test_reset_mid();
        en_mask = 4'b1000;
        write_slot(2'd1, 6'd7, 6'd30);
        write_slot(2'd3, 6'd23, 6'd55);
        pulse_tick(6'd23, 6'd55, 6'd0);
`ifdef ALARM_SNOOZE_EN
        pulse_ctl(1'b1, 1'b0);
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL mid_reset_setup: snoozing=%0b want 1", snoozing); end
`else
        checks++; if (ringing !== 1'b1) begin errors++; $display("FAIL mid_reset_setup: ringing=%0b want 1", ringing); end
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (ringing !== 1'b0 || snoozing !== 1'b0 || ring_id !== 2'd0) begin errors++; $display("FAIL mid_reset_outputs: ringing=%0b snoozing=%0b id=%0d want 0/0/0", ringing, snoozing, ring_id); end
        @(negedge clk);
        reset = 1'b1;
        pulse_tick(6'd0, 6'd4, 6'd0);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL mid_reset_no_retrigger: got %0b want 0", ringing); end
        en_mask = 4'b0010;
        pulse_tick(6'd7, 6'd30, 6'd0);
        checks++; if (ringing !== 1'b0) begin errors++; $display("FAIL slot_cleared_old_time: got %0b want 0", ringing); end
        pulse_tick(6'd0, 6'd0, 6'd0);
        checks++; if (ringing !== 1'b1 || ring_id !== 2'd1) begin errors++; $display("FAIL slot_cleared_midnight: ringing=%0b id=%0d want 1/1", ringing, ring_id); end
        pulse_ctl(1'b0, 1'b1);
    endtask

    initial begin
        wr_bus.wr_en = 1'b0; wr_bus.wr_sel = '0; wr_bus.wr_hour = '0; wr_bus.wr_min = '0;
        test_reset();
        test_single_ring();
        test_bad_write();
        test_priority();
        test_en_clear();
        test_timeout();
        test_snooze();
        test_snooze_and_dismiss();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_alarm_ctrl.md
MULTI_ALARM_CTRL -- requirements
Module: multi_alarm_ctrl

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm slots (2..8).
REQ-002 Parameter SNOOZE_MIN, default 9: snooze length in minutes (1..59).
REQ-003 Parameter RING_TIMEOUT_S, default 60: seconds of unanswered ringing before auto-dismiss (1..255).
REQ-004 clk  in  1  system clock (1 kHz domain).
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 tick_1hz  in  1  one-clk pulse per real-time second.
REQ-007 hour_in, min_in, sec_in  in  6 each  current real time, 24 h format.
REQ-008 wr_en  in  1  one-clk pulse that loads slot wr_sel.
REQ-009 wr_sel  in  $clog2(NUM_ALARMS)  slot index for the write.
REQ-010 wr_hour, wr_min  in  6 each  alarm time to load.
REQ-011 en_mask  in  NUM_ALARMS  per-slot arm bits.
REQ-012 snooze, dismiss  in  1 each  debounced one-clk pulses.
REQ-013 ringing  out  1  alarm sounding.
REQ-014 ring_id  out  $clog2(NUM_ALARMS)  slot that triggered the current ring.
REQ-015 snoozing  out  1  snooze interval in progress.
REQ-016 alarm_on  out  1  OR of en_mask.

Function
REQ-017 Slot registers hold hour/min; a wr_en write takes effect on the next clk edge; writes with hour>23, min>59 or wr_sel>=NUM_ALARMS are ignored.
REQ-018 FSM states: IDLE, RING, SNOOZE.
REQ-019 Match for slot k: en_mask[k] && hour_in==slot_hour[k] && min_in==slot_min[k] && sec_in==0 && tick_1hz.
REQ-020 IDLE->RING on any match; ring_id = lowest matching index; ringing asserts the cycle after the match.
REQ-021 In RING, matches of other slots are ignored (no queueing).
REQ-022 RING->IDLE on dismiss, on timeout counter reaching RING_TIMEOUT_S ticks, or when en_mask[ring_id] clears.
REQ-023 RING->SNOOZE on snooze; target = current hour:min + SNOOZE_MIN; minutes wrap at 60 with carry into hours, hours wrap at 24 (23:55 + 9 = 00:04).
REQ-024 SNOOZE->RING when hour_in:min_in equals target with sec_in==0 and tick_1hz; the timeout counter restarts from 0; ring_id is unchanged.
REQ-025 SNOOZE->IDLE on dismiss or when en_mask[ring_id] clears.
REQ-026 The timeout counter increments on tick_1hz only in RING and clears on every entry to RING.
REQ-027 Simultaneous snooze and dismiss: dismiss wins.
REQ-028 A write to slot ring_id during RING or SNOOZE does not cancel the ring or snooze.
REQ-029 Snooze pulses in IDLE or SNOOZE are ignored.

Reset
REQ-030 On reset low, all outputs clear asynchronously: ringing=0, snoozing=0, ring_id=0. The FSM returns to IDLE, counters clear and all slots are set to 00:00; alarm_on follows en_mask combinationally.
REQ-031 Reset asserted mid-ring or mid-snooze abandons the event; there is no re-trigger until the next match.

Configuration
REQ-032 Macro ALARM_SNOOZE_EN: when defined, the SNOOZE state and snoozing output behave as above.
REQ-033 When ALARM_SNOOZE_EN is undefined, the snooze input is ignored, SNOOZE is unreachable, snoozing is tied to 0 and the target registers are not built.

Structure
REQ-034 A shared package alarm_pkg holds the FSM state enum, the constants MAX_HOUR=23 and MAX_MIN=59, and the slot time struct {hour[5:0], min[5:0]}.
REQ-035 A single sub-module, time_add_min, computes the wrapped hour:min + N minutes for the snooze target.

Verification
REQ-036 Slot 1 armed at 07:30; time reaches 07:30:00 with tick -> ringing=1 next clk, ring_id=1.
REQ-037 Slots 0 and 2 both at 06:00 and both armed -> ring_id=0; slot 2 does not ring afterwards.
REQ-038 Ring at 23:55, snooze pulse -> snoozing=1; at 00:04:00 -> ringing=1, ring_id unchanged.
REQ-039 Ring with no input for 60 ticks -> ringing=0 after the 60th tick and the FSM returns to IDLE.
REQ-040 Snooze and dismiss in the same clk during RING -> IDLE, snoozing stays 0.
REQ-041 Reset pulsed low during SNOOZE -> all outputs 0 at once; slot times read 00:00.
